// File: rtl/dft_multi_chain_ctrl_if.sv
// Host-side handshake and dump-data bundle of the multi-chain scan-dump controller.
interface dft_multi_chain_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             val_op;
  logic             op;
  logic [CNT_W-1:0] dump_nbr;
  logic             op_ack;
  logic             op_commit;
  logic             commit_ack;
  logic [31:0]      dft_out;
  logic             dft_out_strobe;

  modport master (
    output val_op, op, dump_nbr, commit_ack,
    input  op_ack, op_commit, dft_out, dft_out_strobe
  );

  modport slave (
    input  val_op, op, dump_nbr, commit_ack,
    output op_ack, op_commit, dft_out, dft_out_strobe
  );
endinterface

// File: rtl/dft_multi_chain_ctrl.sv
// Scan-dump controller for NUM_CHAINS recirculated scan chains: optional functional
// step, full-length shift with per-chain capture, then word-packed emission.
module dft_multi_chain_ctrl #(
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned CHAIN_LEN  = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  dft_multi_chain_ctrl_if.slave host,
  input  logic                  ex_sen,
  output logic                  sc_sen,
  output logic                  sc_ce,
  input  logic [NUM_CHAINS-1:0] sc_sout,
  output logic [NUM_CHAINS-1:0] sc_sin
);
  localparam int unsigned WPC = (CHAIN_LEN + 31) / 32;
  localparam int unsigned NW  = NUM_CHAINS * WPC;
  localparam int unsigned SW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned EW  = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {IDLE, ACK, STEP, SHIFT, EMIT, COMMIT} state_t;

  state_t           state;
  logic             op_q;
  logic [CNT_W-1:0] rounds;
  logic [CNT_W-1:0] rounds_dec;
  logic [SW-1:0]    shift_cnt;
  logic [EW-1:0]    emit_idx;
  logic             sen_q;
  logic [31:0]      cap   [NW];
  logic [31:0]      cap_d [NW];

  assign sc_sen     = sen_q | ex_sen;
  assign sc_sin     = sc_sout;
  assign rounds_dec = rounds - CNT_W'(1);

  // Capture buffer with the current shift bit merged in, so the first emitted word
  // already contains the bit sampled on the final shift edge.
  always_comb begin
    logic [4:0]  bit_i;
    logic [EW-1:0] idx;
    cap_d = cap;
    bit_i = 5'(shift_cnt);
    idx   = '0;
    if (state == SHIFT) begin
      for (int c = 0; c < int'(NUM_CHAINS); c++) begin
        idx = EW'(32'(c) * WPC + (32'(shift_cnt) >> 5));
        cap_d[idx][bit_i] = sc_sout[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      op_q                 <= 1'b0;
      rounds               <= '0;
      shift_cnt            <= '0;
      emit_idx             <= '0;
      sen_q                <= 1'b0;
      sc_ce                <= 1'b0;
      host.op_ack          <= 1'b0;
      host.op_commit       <= 1'b0;
      host.dft_out         <= '0;
      host.dft_out_strobe  <= 1'b0;
      for (int i = 0; i < int'(NW); i++) cap[i] <= '0;
    end else begin
      host.op_ack <= 1'b0;
      cap         <= cap_d;
      case (state)
        IDLE: begin
          if (host.val_op) begin
            op_q        <= host.op;
            rounds      <= host.dump_nbr;
            host.op_ack <= 1'b1;
            state       <= ACK;
          end
        end
        ACK: begin
          if (op_q) begin
            rounds    <= CNT_W'(1);
            sc_ce     <= 1'b1;
            sen_q     <= 1'b1;
            shift_cnt <= '0;
            state     <= SHIFT;
          end else if (rounds == '0) begin
            host.op_commit <= 1'b1;
            state          <= COMMIT;
          end else begin
            sc_ce <= 1'b1;
            state <= STEP;
          end
        end
        STEP: begin
          sen_q     <= 1'b1;
          shift_cnt <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (shift_cnt == SW'(CHAIN_LEN - 1)) begin
            sc_ce               <= 1'b0;
            sen_q               <= 1'b0;
            emit_idx            <= '0;
            host.dft_out        <= cap_d[0];
            host.dft_out_strobe <= 1'b1;
            state               <= EMIT;
          end else begin
            shift_cnt <= shift_cnt + SW'(1);
          end
        end
        EMIT: begin
          if (emit_idx == EW'(NW - 1)) begin
            host.dft_out        <= '0;
            host.dft_out_strobe <= 1'b0;
            rounds              <= rounds_dec;
            // Another round only for DUMP with rounds remaining.
            if (rounds_dec != '0 && !op_q) begin
              sc_ce <= 1'b1;
              state <= STEP;
            end else begin
              host.op_commit <= 1'b1;
              state          <= COMMIT;
            end
          end else begin
            emit_idx     <= emit_idx + EW'(1);
            host.dft_out <= cap[emit_idx + EW'(1)];
          end
        end
        COMMIT: begin
          if (host.commit_ack) begin
            host.op_commit <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dft_multi_chain_ctrl.sv
// Directed bench: two controller instances (4x32 and 2x40) with behavioural scan chains.
module tb_dft_multi_chain_ctrl;
  logic        clk;
  logic        reset;
  logic        val_op;
  logic        op;
  logic [15:0] dump_nbr;
  logic        commit_ack;
  logic        ex_sen;
  logic        use_b;

  logic [3:0]  sc_sout_a, sc_sin_a;
  logic        sc_sen_a, sc_ce_a;
  logic [1:0]  sc_sout_b, sc_sin_b;
  logic        sc_sen_b, sc_ce_b;

  logic [31:0] cha [4];
  logic [39:0] chb [2];
  logic [31:0] pre_a [4];
  logic [39:0] pre_b [2];
  logic        pre_en;

  int n_vec;
  int n_miss;

  // per-operation observations
  int          n_ack, ack_at, n_step, first_step, n_shift, n_words, last_strobe, commit_at, drop_at;
  logic [31:0] words [16];

  dft_multi_chain_ctrl_if #(.CNT_W(16)) ha ();
  dft_multi_chain_ctrl_if #(.CNT_W(16)) hb ();

  assign ha.val_op     = val_op & ~use_b;
  assign ha.op         = op;
  assign ha.dump_nbr   = dump_nbr;
  assign ha.commit_ack = commit_ack;
  assign hb.val_op     = val_op & use_b;
  assign hb.op         = op;
  assign hb.dump_nbr   = dump_nbr;
  assign hb.commit_ack = commit_ack;

  dft_multi_chain_ctrl #(.NUM_CHAINS(4), .CHAIN_LEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .host(ha), .ex_sen(ex_sen),
    .sc_sen(sc_sen_a), .sc_ce(sc_ce_a), .sc_sout(sc_sout_a), .sc_sin(sc_sin_a)
  );

  dft_multi_chain_ctrl #(.NUM_CHAINS(2), .CHAIN_LEN(40), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .host(hb), .ex_sen(ex_sen),
    .sc_sen(sc_sen_b), .sc_ce(sc_ce_b), .sc_sout(sc_sout_b), .sc_sin(sc_sin_b)
  );

  logic        p_ack, p_commit, p_strobe, p_ce, p_sen;
  logic [31:0] p_dout;
  assign p_ack    = use_b ? hb.op_ack         : ha.op_ack;
  assign p_commit = use_b ? hb.op_commit      : ha.op_commit;
  assign p_strobe = use_b ? hb.dft_out_strobe : ha.dft_out_strobe;
  assign p_dout   = use_b ? hb.dft_out        : ha.dft_out;
  assign p_ce     = use_b ? sc_ce_b           : sc_ce_a;
  assign p_sen    = use_b ? sc_sen_b          : sc_sen_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain models: LSB shifts out; chain 0 of the 4x32 DUT counts on each functional clock.
  always_comb begin
    for (int c = 0; c < 4; c++) sc_sout_a[c] = cha[c][0];
    for (int c = 0; c < 2; c++) sc_sout_b[c] = chb[c][0];
  end

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (pre_en)                cha[c] <= pre_a[c];
      else if (sc_ce_a && sc_sen_a) cha[c] <= {sc_sin_a[c], cha[c][31:1]};
      else if (sc_ce_a && c == 0) cha[c] <= cha[c] + 32'd1;
    end
    for (int c = 0; c < 2; c++) begin
      if (pre_en)                chb[c] <= pre_b[c];
      else if (sc_ce_b && sc_sen_b) chb[c] <= {sc_sin_b[c], chb[c][39:1]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload_a(input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
    @(negedge clk);
    pre_a[0] = v0; pre_a[1] = v1; pre_a[2] = v2; pre_a[3] = v3;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one request and observe it cycle by cycle; c counts cycles after the accepting edge.
  task automatic run_op(input logic o, input logic [15:0] n, input int pulse_at,
                        input int rst_at, input int ack_hold);
    int c;
    bit done;
    n_ack = 0; ack_at = -1; n_step = 0; first_step = -1; n_shift = 0;
    n_words = 0; last_strobe = -1; commit_at = -1; drop_at = -1;
    @(negedge clk);
    val_op = 1'b1; op = o; dump_nbr = n; commit_ack = 1'b0;
    c = 0; done = 1'b0;
    while (!done && c < 1000) begin
      @(negedge clk);
      c++;
      val_op = (c == pulse_at);
      if (p_ack) begin n_ack++; ack_at = c; end
      if (p_ce && !p_sen) begin n_step++; if (first_step < 0) first_step = c; end
      if (p_ce && p_sen) n_shift++;
      if (p_strobe) begin
        if (n_words < 16) words[n_words] = p_dout;
        n_words++;
        last_strobe = c;
      end
      if (rst_at > 0) begin
        if (c == rst_at) reset = 1'b1;
        if (c == rst_at + 1) begin
          chk("abort_idle", {60'd0, p_ce, p_sen, p_strobe, p_commit}, 64'd0);
          reset = 1'b0;
        end
        if (p_commit && commit_at < 0) commit_at = c;
        if (c == rst_at + 30) done = 1'b1;
      end else if (p_commit) begin
        if (commit_at < 0) commit_at = c;
        if (c - commit_at >= ack_hold) commit_ack = 1'b1;
      end else if (commit_at >= 0) begin
        drop_at = c;
        commit_ack = 1'b0;
        done = 1'b1;
      end
    end
    val_op = 1'b0; commit_ack = 1'b0; reset = 1'b0;
    chk("op_done", 64'(done), 64'd1);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    pre_en = 1'b0; use_b = 1'b0; ex_sen = 1'b0;
    for (int i = 0; i < 4; i++) pre_a[i] = '0;
    for (int i = 0; i < 2; i++) pre_b[i] = '0;
    reset = 1'b1; val_op = 1'b1; commit_ack = 1'b1; op = 1'b0; dump_nbr = 16'd1;

    // reset held with request and ack asserted
    repeat (3) @(negedge clk);
    chk("rst_ack",    64'(p_ack),    64'd0);
    chk("rst_commit", 64'(p_commit), 64'd0);
    chk("rst_strobe", 64'(p_strobe), 64'd0);
    chk("rst_dout",   64'(p_dout),   64'd0);
    chk("rst_scan",   {62'd0, p_ce, p_sen}, 64'd0);
    reset = 1'b0; val_op = 1'b0; commit_ack = 1'b0;
    @(negedge clk);
    chk("rst_no_ack", 64'(p_ack), 64'd0);

    // SNAP on the 4x32 instance
    preload_a(32'hDEADBEEF, 32'h12345678, 32'h0, 32'hFFFFFFFF);
    run_op(1'b1, 16'd7, -1, -1, 0);
    chk("snap_ack_at", 64'(ack_at),  64'd1);
    chk("snap_n_ack",  64'(n_ack),   64'd1);
    chk("snap_step",   64'(n_step),  64'd0);
    chk("snap_shift",  64'(n_shift), 64'd32);
    chk("snap_words",  64'(n_words), 64'd4);
    chk("snap_w0", 64'(words[0]), 64'hDEADBEEF);
    chk("snap_w1", 64'(words[1]), 64'h12345678);
    chk("snap_w2", 64'(words[2]), 64'h0);
    chk("snap_w3", 64'(words[3]), 64'hFFFFFFFF);
    chk("snap_last_strobe", 64'(last_strobe), 64'd37);
    chk("snap_commit_at",   64'(commit_at),   64'd38);
    chk("snap_commit_len",  64'(drop_at - commit_at), 64'd1);
    chk("snap_keep0", 64'(cha[0]), 64'hDEADBEEF);
    chk("snap_keep1", 64'(cha[1]), 64'h12345678);
    chk("snap_keep2", 64'(cha[2]), 64'h0);
    chk("snap_keep3", 64'(cha[3]), 64'hFFFFFFFF);

    // DUMP x3 with chain 0 counting from 5
    preload_a(32'd5, 32'hCAFEF00D, 32'h0F0F0F0F, 32'h80000001);
    run_op(1'b0, 16'd3, -1, -1, 0);
    chk("dump_n_ack",      64'(n_ack),      64'd1);
    chk("dump_first_step", 64'(first_step), 64'd2);
    chk("dump_steps",      64'(n_step),     64'd3);
    chk("dump_shift",      64'(n_shift),    64'd96);
    chk("dump_words",      64'(n_words),    64'd12);
    chk("dump_r1_c0", 64'(words[0]),  64'd6);
    chk("dump_r2_c0", 64'(words[4]),  64'd7);
    chk("dump_r3_c0", 64'(words[8]),  64'd8);
    chk("dump_r1_c1", 64'(words[1]),  64'hCAFEF00D);
    chk("dump_r3_c3", 64'(words[11]), 64'h80000001);
    chk("dump_last_strobe", 64'(last_strobe), 64'd112);
    chk("dump_commit_at",   64'(commit_at),   64'd113);
    chk("dump_cnt_final",   64'(cha[0]),      64'd8);

    // DUMP with zero rounds, commit_ack withheld 5 cycles
    run_op(1'b0, 16'd0, -1, -1, 5);
    chk("zero_ack_at",     64'(ack_at),  64'd1);
    chk("zero_step",       64'(n_step),  64'd0);
    chk("zero_shift",      64'(n_shift), 64'd0);
    chk("zero_words",      64'(n_words), 64'd0);
    chk("zero_commit_at",  64'(commit_at), 64'd2);
    chk("zero_commit_len", 64'(drop_at - commit_at), 64'd6);

    // request while busy, then reset during shift cycle 10
    run_op(1'b1, 16'd1, 5, 12, 0);
    chk("busy_n_ack",   64'(n_ack),     64'd1);
    chk("abort_words",  64'(n_words),   64'd0);
    chk("abort_commit", 64'(commit_at), 64'hFFFFFFFFFFFFFFFF);

    // fresh SNAP after abort
    preload_a(32'h01234567, 32'h89ABCDEF, 32'h55AA55AA, 32'h00000080);
    run_op(1'b1, 16'd0, -1, -1, 0);
    chk("resnap_words", 64'(n_words), 64'd4);
    chk("resnap_w0", 64'(words[0]), 64'h01234567);
    chk("resnap_w1", 64'(words[1]), 64'h89ABCDEF);
    chk("resnap_w2", 64'(words[2]), 64'h55AA55AA);
    chk("resnap_w3", 64'(words[3]), 64'h00000080);
    chk("resnap_commit_at", 64'(commit_at), 64'd38);

    // 2x40 instance: two words per chain
    use_b = 1'b1;
    @(negedge clk);
    pre_b[0] = 40'hA5_0000_0001; pre_b[1] = 40'h12_8765_4321;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    run_op(1'b1, 16'd0, -1, -1, 0);
    chk("b_ack_at", 64'(ack_at),  64'd1);
    chk("b_shift",  64'(n_shift), 64'd40);
    chk("b_words",  64'(n_words), 64'd4);
    chk("b_c0_w0",  64'(words[0]), 64'h00000001);
    chk("b_c0_w1",  64'(words[1]), 64'h000000A5);
    chk("b_c1_w0",  64'(words[2]), 64'h87654321);
    chk("b_c1_w1",  64'(words[3]), 64'h00000012);
    chk("b_commit_at", 64'(commit_at), 64'd46);
    chk("b_keep0", 64'(chb[0]), 64'hA5_0000_0001);
    chk("b_keep1", 64'(chb[1]), 64'h12_8765_4321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
